// File: rtl/sms_pkg.sv
// Shared types and constants for the SMS core backup-RAM logic.
// Latency: none (declarations only).
// Backpressure: not applicable.
package sms_pkg;

    localparam int SECTOR_BYTES = 512;
    localparam int SECTOR_AW    = $clog2(SECTOR_BYTES);

    // Sequencer states: waiting for a trigger, waiting for user_io to take
    // the sector request, and a sector actively moving over the buffer bus.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } bk_state_t;

endpackage

// File: rtl/nvram_backup_if.sv
// user_io sector handshake bundle between the backup sequencer and the SD side.
// Latency: none (wires only).
// Backpressure: the SD side paces every sector through sd_ack.
interface nvram_backup_if;
    import sms_pkg::*;

    logic [31:0]          sd_lba;
    logic                 sd_rd;
    logic                 sd_wr;
    logic                 sd_ack;
    logic [SECTOR_AW-1:0] sd_buff_addr;
    logic                 sd_buff_wr;

    // Sequencer side: issues sector requests, follows the SD buffer bus.
    modport master (
        output sd_lba, sd_rd, sd_wr,
        input  sd_ack, sd_buff_addr, sd_buff_wr
    );

    // user_io side: serves the requests and streams the sector bytes.
    modport slave (
        input  sd_lba, sd_rd, sd_wr,
        output sd_ack, sd_buff_addr, sd_buff_wr
    );

endinterface

// File: rtl/nvram_backup_edge_det.sv
// Registered rise/fall detector for a vector of level signals.
// Latency: rise/fall valid in the same cycle the input changes (one history flop).
// Backpressure: none; every input change is reported exactly once.
module edge_det #(
    parameter int W = 1
) (
    input  logic         clk_sys,
    input  logic         RESET_n,
    input  logic [W-1:0] sig,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] sig_q;

    // One-cycle history of the input.
    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;
    assign fall = ~sig & sig_q;

endmodule

// File: rtl/nvram_backup.sv
// Moves cartridge NVRAM between NVRAM port B and the SD save image, sector by sector.
// Latency: request one cycle after a trigger/ack edge; NVRAM writes follow sd_buff_wr combinationally.
// Backpressure: each sector waits for user_io sd_ack; a missing ack aborts after TIMEOUT cycles.
module nvram_backup
    import sms_pkg::*;
#(
    parameter int SECTORS = 64,
    parameter int SLOT_W  = 2,
    parameter int TIMEOUT = 1 << 24
) (
    input  logic                                clk_sys,
    input  logic                                RESET_n,
    input  logic                                ioctl_download,
    input  logic                                img_mounted,
    input  logic [31:0]                         img_size,
    input  logic                                bk_load,
    input  logic                                bk_save,
    input  logic [SLOT_W-1:0]                   slot,
    nvram_backup_if.master                      sd,
    output logic [$clog2(SECTORS)+SECTOR_AW-1:0] nvram_addr_b,
    output logic                                nvram_we_b,
    output logic                                bk_ena,
    output logic                                busy,
    output logic                                done,
    output logic                                err
);

    localparam int SEC_W = $clog2(SECTORS);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    bk_state_t        state_q, state_nx;
    logic [31:0]      lba_q, lba_nx;
    logic             rd_q, rd_nx;
    logic             wr_q, wr_nx;
    logic             busy_q, busy_nx;
    logic             done_q, done_nx;
    logic             err_q, err_nx;
    logic             loading_q, loading_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic             abort_q;
    logic             dl_q;
    logic             dl_rise;
    logic             bk_ena_q;
    logic             sector_last;
    logic             load_rise, load_fall;
    logic             save_rise, save_fall;
    logic             ack_rise, ack_fall;
    logic [1:0]       unused_fall;

    edge_det #(.W(1)) u_load_edge (
        .clk_sys (clk_sys),
        .RESET_n (RESET_n),
        .sig     (bk_load),
        .rise    (load_rise),
        .fall    (load_fall)
    );

    edge_det #(.W(1)) u_save_edge (
        .clk_sys (clk_sys),
        .RESET_n (RESET_n),
        .sig     (bk_save),
        .rise    (save_rise),
        .fall    (save_fall)
    );

    edge_det #(.W(1)) u_ack_edge (
        .clk_sys (clk_sys),
        .RESET_n (RESET_n),
        .sig     (sd.sd_ack),
        .rise    (ack_rise),
        .fall    (ack_fall)
    );

    // OSD triggers are level requests; only their rising edges matter.
    assign unused_fall = {load_fall, save_fall};

    assign dl_rise     = ioctl_download & ~dl_q;
    assign sector_last = &lba_q[SEC_W-1:0];

    // Save image validity: dropped by each new ROM download, raised by a
    // non-empty mount during it; a mount in the same cycle as the rise wins.
    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            dl_q     <= 1'b0;
            bk_ena_q <= 1'b0;
        end else begin
            dl_q <= ioctl_download;
            if (ioctl_download && img_mounted && (img_size != 32'd0)) begin
                bk_ena_q <= 1'b1;
            end else if (dl_rise) begin
                bk_ena_q <= 1'b0;
            end
        end
    end

    // Abort latch: a download rise stops the running transfer at the next
    // safe point; it self-clears once the sequencer is back in IDLE.
    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            abort_q <= 1'b0;
        end else begin
            abort_q <= dl_rise | (abort_q & (state_nx != ST_IDLE));
        end
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q   <= ST_IDLE;
            lba_q     <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            loading_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_nx;
            lba_q     <= lba_nx;
            rd_q      <= rd_nx;
            wr_q      <= wr_nx;
            busy_q    <= busy_nx;
            done_q    <= done_nx;
            err_q     <= err_nx;
            loading_q <= loading_nx;
            cnt_q     <= cnt_nx;
        end
    end

    // Next-state and output decisions; done/err default low so they pulse.
    always_comb begin
        state_nx   = state_q;
        lba_nx     = lba_q;
        rd_nx      = rd_q;
        wr_nx      = wr_q;
        busy_nx    = busy_q;
        done_nx    = 1'b0;
        err_nx     = 1'b0;
        loading_nx = loading_q;
        cnt_nx     = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if ((load_rise || save_rise) && bk_ena_q) begin
                    // Load wins when both triggers rise together.
                    loading_nx = load_rise;
                    lba_nx     = 32'({slot, {SEC_W{1'b0}}});
                    rd_nx      = load_rise;
                    wr_nx      = ~load_rise;
                    busy_nx    = 1'b1;
                    cnt_nx     = '0;
                    state_nx   = ST_REQ;
                end
            end

            ST_REQ: begin
                if (abort_q) begin
                    rd_nx    = 1'b0;
                    wr_nx    = 1'b0;
                    busy_nx  = 1'b0;
                    state_nx = ST_IDLE;
                end else if (ack_rise) begin
                    rd_nx    = 1'b0;
                    wr_nx    = 1'b0;
                    cnt_nx   = '0;
                    state_nx = ST_XFER;
                end else if (cnt_q == CNT_LAST) begin
                    rd_nx    = 1'b0;
                    wr_nx    = 1'b0;
                    busy_nx  = 1'b0;
                    err_nx   = 1'b1;
                    state_nx = ST_IDLE;
                end else begin
                    cnt_nx = cnt_q + 1'b1;
                end
            end

            ST_XFER: begin
                // The sector in flight always finishes; decisions wait for ack fall.
                if (ack_fall) begin
                    if (sector_last || abort_q) begin
                        busy_nx  = 1'b0;
                        done_nx  = ~abort_q;
                        state_nx = ST_IDLE;
                    end else begin
                        lba_nx   = lba_q + 32'd1;
                        rd_nx    = loading_q;
                        wr_nx    = ~loading_q;
                        cnt_nx   = '0;
                        state_nx = ST_REQ;
                    end
                end
            end

            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign sd.sd_lba = lba_q;
    assign sd.sd_rd  = rd_q;
    assign sd.sd_wr  = wr_q;

    assign nvram_addr_b = {lba_q[SEC_W-1:0], sd.sd_buff_addr};
    assign nvram_we_b   = sd.sd_buff_wr & sd.sd_ack & loading_q & busy_q;

    assign bk_ena = bk_ena_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_nvram_backup.sv
// Self-checking bench for nvram_backup: vector table, directed sequences, random transfers.
// Latency: checks sample on the falling clock edge, inputs change there too.
// Backpressure: the bench plays user_io, acking each sector after a chosen delay.
module tb_nvram_backup;

    localparam int SECTORS = 64;
    localparam int SLOT_W  = 2;
    localparam int TIMEOUT = 16;

    logic              clk_sys        = 1'b0;
    logic              RESET_n        = 1'b0;
    logic              ioctl_download = 1'b0;
    logic              img_mounted    = 1'b0;
    logic [31:0]       img_size       = 32'd0;
    logic              bk_load        = 1'b0;
    logic              bk_save        = 1'b0;
    logic [SLOT_W-1:0] slot           = '0;
    logic [14:0]       nvram_addr_b;
    logic              nvram_we_b;
    logic              bk_ena;
    logic              busy;
    logic              done;
    logic              err;

    nvram_backup_if sd();

    nvram_backup #(
        .SECTORS (SECTORS),
        .SLOT_W  (SLOT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_sys        (clk_sys),
        .RESET_n        (RESET_n),
        .ioctl_download (ioctl_download),
        .img_mounted    (img_mounted),
        .img_size       (img_size),
        .bk_load        (bk_load),
        .bk_save        (bk_save),
        .slot           (slot),
        .sd             (sd),
        .nvram_addr_b   (nvram_addr_b),
        .nvram_we_b     (nvram_we_b),
        .bk_ena         (bk_ena),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk_sys = ~clk_sys;

    int errors = 0;
    int checks = 0;

    // Event counters kept by the monitor below.
    int   done_cnt  = 0;
    int   err_cnt   = 0;
    int   req_rd    = 0;
    int   req_wr    = 0;
    int   pulse_bad = 0;
    logic done_p = 1'b0, err_p = 1'b0, busy_p = 1'b0;

    always @(negedge clk_sys) begin
        if (done) done_cnt++;
        if (err)  err_cnt++;
        if ((done && done_p) || (err && err_p)) pulse_bad++;
        if ((done || err) && (busy || !busy_p)) pulse_bad++;
        if (sd.sd_rd) req_rd++;
        if (sd.sd_wr) req_wr++;
        done_p = done;
        err_p  = err;
        busy_p = busy;
    end

    typedef struct {
        logic        dl;
        logic        mnt;
        logic [31:0] size;
        logic        exp_ena;
    } ena_vec_t;

    ena_vec_t tv [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic mount();
        ioctl_download = 1'b1;
        img_mounted    = 1'b1;
        img_size       = 32'd32768;
        @(negedge clk_sys);
        img_mounted = 1'b0;
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        @(negedge clk_sys);
    endtask

    // Play user_io for one sector: wait for the request, check it, ack,
    // optionally stream bytes and/or raise a download mid-sector.
    task automatic serve(input logic exp_rd, input logic [31:0] exp_lba, input int dly,
                         input int nbytes, input bit abort_here);
        int         w;
        int         bad;
        logic [14:0] ea;
        w = 0;
        while (!(sd.sd_rd || sd.sd_wr) && w < 40) begin
            @(negedge clk_sys);
            w++;
        end
        check("req_seen", 64'(w < 40), 64'(1));
        check("req_rd",   64'(sd.sd_rd), 64'(exp_rd));
        check("req_wr",   64'(sd.sd_wr), 64'(!exp_rd));
        check("req_lba",  64'(sd.sd_lba), 64'(exp_lba));
        repeat (dly) @(negedge clk_sys);
        sd.sd_ack = 1'b1;
        repeat (2) @(negedge clk_sys);
        check("req_drop", 64'(sd.sd_rd | sd.sd_wr), 64'(0));
        if (abort_here) begin
            ioctl_download = 1'b1;
            @(negedge clk_sys);
            ioctl_download = 1'b0;
        end
        bad = 0;
        for (int b = 0; b < nbytes; b++) begin
            sd.sd_buff_addr = 9'(b);
            sd.sd_buff_wr   = 1'b1;
            #2;
            ea = {exp_lba[5:0], 9'(b)};
            if (nvram_we_b !== exp_rd) bad++;
            if (exp_rd && nvram_addr_b !== ea) bad++;
            @(negedge clk_sys);
        end
        sd.sd_buff_wr   = 1'b0;
        sd.sd_buff_addr = '0;
        if (nbytes > 0) check("nvram_bytes", 64'(bad), 64'(0));
        sd.sd_ack = 1'b0;
        @(negedge clk_sys);
    endtask

    // One whole transfer against the reference rule: sectors slot*SECTORS+i
    // in order, stopping after abort_sec when given, done only without abort.
    task automatic run_xfer(input logic is_load, input logic [1:0] s, input int abort_sec,
                            input int nbytes, input bit rnd);
        int d0, e0, r0, last;
        d0   = done_cnt;
        e0   = err_cnt;
        last = (abort_sec >= 0) ? abort_sec : SECTORS - 1;
        slot = s;
        if (is_load) bk_load = 1'b1;
        else         bk_save = 1'b1;
        @(negedge clk_sys);
        check("trig_busy", 64'(busy), 64'(1));
        check("trig_req",  64'({sd.sd_rd, sd.sd_wr}), is_load ? 64'(2) : 64'(1));
        for (int i = 0; i <= last; i++) begin
            serve(is_load, 32'(int'(s) * SECTORS + i),
                  rnd ? int'($urandom_range(0, 8)) : 0,
                  rnd ? int'($urandom_range(0, 3)) : nbytes,
                  (i == abort_sec));
        end
        bk_load = 1'b0;
        bk_save = 1'b0;
        repeat (4) @(negedge clk_sys);
        r0 = req_rd + req_wr;
        check("end_busy", 64'(busy), 64'(0));
        check("end_done", 64'(done_cnt - d0), (abort_sec < 0) ? 64'(1) : 64'(0));
        check("end_err",  64'(err_cnt - e0), 64'(0));
        repeat (20) @(negedge clk_sys);
        check("no_extra_req", 64'(req_rd + req_wr - r0), 64'(0));
    endtask

    initial begin
        int r0, w0, cnt, ab;
        logic ld;
        logic [1:0] s;

        tv[0]  = '{1'b0, 1'b0, 32'd0,     1'b0};
        tv[1]  = '{1'b1, 1'b0, 32'd0,     1'b0};
        tv[2]  = '{1'b1, 1'b1, 32'd32768, 1'b1};
        tv[3]  = '{1'b1, 1'b0, 32'd0,     1'b1};
        tv[4]  = '{1'b0, 1'b0, 32'd0,     1'b1};
        tv[5]  = '{1'b0, 1'b1, 32'd32768, 1'b1};
        tv[6]  = '{1'b1, 1'b0, 32'd0,     1'b0};
        tv[7]  = '{1'b1, 1'b1, 32'd0,     1'b0};
        tv[8]  = '{1'b0, 1'b0, 32'd0,     1'b0};
        tv[9]  = '{1'b1, 1'b1, 32'd512,   1'b1};
        tv[10] = '{1'b0, 1'b0, 32'd0,     1'b1};
        tv[11] = '{1'b1, 1'b0, 32'd0,     1'b0};

        sd.sd_ack       = 1'b0;
        sd.sd_buff_addr = '0;
        sd.sd_buff_wr   = 1'b0;

        // Reset state, both during and after reset.
        #1;
        check("rst_outs", 64'({sd.sd_lba, sd.sd_rd, sd.sd_wr, busy, done, err, bk_ena, nvram_we_b}), 64'(0));
        repeat (3) @(negedge clk_sys);
        RESET_n = 1'b1;
        @(negedge clk_sys);
        check("post_rst_outs", 64'({sd.sd_lba, sd.sd_rd, sd.sd_wr, busy, done, err, bk_ena, nvram_addr_b}), 64'(0));

        // bk_ena set/clear table.
        for (int i = 0; i < 12; i++) begin
            ioctl_download = tv[i].dl;
            img_mounted    = tv[i].mnt;
            img_size       = tv[i].size;
            @(negedge clk_sys);
            check($sformatf("bk_ena_vec%0d", i), 64'(bk_ena), 64'(tv[i].exp_ena));
        end
        ioctl_download = 1'b0;
        img_mounted    = 1'b0;
        @(negedge clk_sys);

        // Save to slot 2: sectors 128..191, no read request ever.
        mount();
        r0 = req_rd;
        run_xfer(1'b0, 2'd2, -1, 0, 1'b0);
        check("save_no_rd", 64'(req_rd - r0), 64'(0));

        // Load slot 0 with full sectors: NVRAM 0x0000..0x7FFF written in order.
        w0 = req_wr;
        run_xfer(1'b1, 2'd0, -1, 512, 1'b0);
        check("load_no_wr", 64'(req_wr - w0), 64'(0));

        // Both triggers together: load wins; a later save rise is ignored.
        slot    = 2'd1;
        bk_load = 1'b1;
        bk_save = 1'b1;
        @(negedge clk_sys);
        check("both_rd", 64'(sd.sd_rd), 64'(1));
        check("both_wr", 64'(sd.sd_wr), 64'(0));
        r0 = done_cnt;
        for (int i = 0; i < SECTORS; i++) begin
            if (i == 10) begin
                bk_save = 1'b0;
                @(negedge clk_sys);
                bk_save = 1'b1;
            end
            serve(1'b1, 32'(SECTORS + i), 1, 0, 1'b0);
        end
        bk_load = 1'b0;
        bk_save = 1'b0;
        repeat (4) @(negedge clk_sys);
        check("both_done", 64'(done_cnt - r0), 64'(1));
        check("both_idle", 64'(busy), 64'(0));

        // Timeout: ack never comes, err exactly TIMEOUT cycles after the request.
        slot    = 2'd3;
        r0      = err_cnt;
        bk_save = 1'b1;
        @(negedge clk_sys);
        check("to_req", 64'(sd.sd_wr), 64'(1));
        cnt = 0;
        while (!err && cnt < 40) begin
            @(negedge clk_sys);
            cnt++;
        end
        check("to_cycles", 64'(cnt), 64'(TIMEOUT));
        check("to_req_drop", 64'(sd.sd_rd | sd.sd_wr), 64'(0));
        check("to_busy", 64'(busy), 64'(0));
        bk_save = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("to_err_once", 64'(err_cnt - r0), 64'(1));

        // Same without a valid image: nothing happens.
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        check("noena_ena", 64'(bk_ena), 64'(0));
        r0      = req_rd + req_wr;
        w0      = err_cnt;
        bk_save = 1'b1;
        repeat (24) @(negedge clk_sys);
        check("noena_req",  64'(req_rd + req_wr - r0), 64'(0));
        check("noena_busy", 64'(busy), 64'(0));
        check("noena_err",  64'(err_cnt - w0), 64'(0));
        bk_save = 1'b0;
        @(negedge clk_sys);

        // Asynchronous reset in the middle of a sector.
        mount();
        slot    = 2'd1;
        bk_load = 1'b1;
        @(negedge clk_sys);
        sd.sd_ack = 1'b1;
        repeat (2) @(negedge clk_sys);
        sd.sd_buff_wr = 1'b1;
        #1;
        check("xfer_we", 64'(nvram_we_b), 64'(1));
        #1;
        RESET_n = 1'b0;
        #1;
        check("async_rst_outs", 64'({sd.sd_lba, sd.sd_rd, sd.sd_wr, busy, done, err, bk_ena, nvram_we_b, nvram_addr_b}), 64'(0));
        sd.sd_buff_wr = 1'b0;
        sd.sd_ack     = 1'b0;
        bk_load       = 1'b0;
        @(negedge clk_sys);
        RESET_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        // Download during sector 5: sector 5 finishes, then stop without done.
        mount();
        run_xfer(1'b1, 2'd1, 5, 4, 1'b0);

        // Random transfers against the sector-sequence rule.
        for (int r = 0; r < 8; r++) begin
            mount();
            ld = 1'($urandom_range(0, 1));
            s  = 2'($urandom_range(0, 3));
            ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, SECTORS - 1)) : -1;
            run_xfer(ld, s, ab, 0, 1'b1);
        end

        check("pulse_shape", 64'(pulse_bad), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
